// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the byte-serial RAM port
// controller.
//   mc_state_t  - controller FSM state encoding
//   mc_port_t   - which requester owns the current transfer
//   MEM_SIZE_*  - access size codes as presented by the MEM stage
//   ram_addr_t  - RAM byte address at the default 17-bit width
//   mem_data_t  - 32-bit data bus between the pipeline and the controller
//   mc_dbg_t    - bundled FSM view for checkers and waveform probing
//   size_to_len - access size code -> number of byte transfers
package mem_ctrl_pkg;

  localparam int RAM_ADDR_W_DEF = 17;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_RD   = 2'd1,
    MC_WR   = 2'd2,
    MC_DONE = 2'd3
  } mc_state_t;

  typedef enum logic {
    PORT_IF  = 1'b0,
    PORT_MEM = 1'b1
  } mc_port_t;

  typedef logic [RAM_ADDR_W_DEF-1:0] ram_addr_t;
  typedef logic [31:0]               mem_data_t;

  typedef struct packed {
    mc_state_t  state;
    logic [2:0] cnt;
    mc_port_t   port;
  } mc_dbg_t;

  // Size code 2'b11 is deliberately folded into the word case.
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    logic [2:0] len;
    case (size)
      MEM_SIZE_B: len = 3'd1;
      MEM_SIZE_H: len = 3'd2;
      default:    len = 3'd4;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates one byte-wide synchronous RAM port between instruction
// fetch (IF) and the MEM stage, serialising each byte/half/word access into
// little-endian byte transfers.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   if_req_i         fetch request          if_addr_i   fetch byte address
//   if_data_o        fetched word           if_done_o   fetch completion pulse
//   mem_req_i        data request           mem_we_i    1=store, 0=load
//   mem_size_i       00 byte, 01 half, 1x word
//   mem_addr_i       data byte address      mem_wdata_i store data, right-aligned
//   mem_rdata_o      load data, zero-ext.   mem_done_o  data completion pulse
//   ram_a_o          RAM byte address       ram_dout_o  byte written to RAM
//   ram_din_i        byte read from RAM (valid one cycle after its address)
//   ram_wr_o         RAM write strobe
//
// Handshake: a requester raises req with stable address/size/data and holds
// it until it sees its one-cycle done pulse; it drops req on the clock edge
// that ends the done cycle. Requests are only sampled in IDLE, MEM wins over
// IF, and read data is valid in the done cycle and held until the next
// completion on the same port.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [31:0]           if_addr_i,
  output logic [31:0]           if_data_o,
  output logic                  if_done_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_size_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_done_o,
  output logic [RAM_ADDR_W-1:0] ram_a_o,
  output logic [7:0]            ram_dout_o,
  input  logic [7:0]            ram_din_i,
  output logic                  ram_wr_o
);

  mc_state_t             state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            len_q;
  mc_port_t              port_q;
  logic [RAM_ADDR_W-1:0] base_q;
  logic [RAM_ADDR_W-1:0] last_a_q;
  mem_data_t             wdata_q;
  mem_data_t             rbuf_q, rbuf_next;
  mem_data_t             if_data_q, mem_rdata_q;

  logic                  addr_phase;
  logic [RAM_ADDR_W-1:0] cur_a;
  logic [7:0]            wr_byte;

  // Address bits above the RAM width are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{if_addr_i[31:RAM_ADDR_W], mem_addr_i[31:RAM_ADDR_W]};

  // Probe point bundling the FSM view for checkers.
  mc_dbg_t dbg_unused;
  assign dbg_unused = '{state: state_q, cnt: cnt_q, port: port_q};

  // base+cnt wraps naturally at the RAM width.
  assign cur_a = base_q + RAM_ADDR_W'(cnt_q);

  // The RAM sees an address in every WR cycle, and in RD cycles before the
  // final capture-only cycle (cnt==N).
  assign addr_phase = (state_q == MC_WR) ||
                      ((state_q == MC_RD) && (cnt_q < len_q));

  // ram_din_i answers the address of the previous cycle, so the byte seen at
  // cnt belongs to lane cnt-1.
  always_comb begin
    rbuf_next = rbuf_q;
    if (state_q == MC_RD) begin
      case (cnt_q)
        3'd1:    rbuf_next[7:0]   = ram_din_i;
        3'd2:    rbuf_next[15:8]  = ram_din_i;
        3'd3:    rbuf_next[23:16] = ram_din_i;
        3'd4:    rbuf_next[31:24] = ram_din_i;
        default: rbuf_next = rbuf_q;
      endcase
    end
  end

  always_comb begin
    case (cnt_q[1:0])
      2'd0:    wr_byte = wdata_q[7:0];
      2'd1:    wr_byte = wdata_q[15:8];
      2'd2:    wr_byte = wdata_q[23:16];
      default: wr_byte = wdata_q[31:24];
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MC_IDLE: begin
        cnt_d = 3'd0;
        if (mem_req_i) begin
          state_d = mem_we_i ? MC_WR : MC_RD;
        end else if (if_req_i) begin
          state_d = MC_RD;
        end
      end
      MC_RD: begin
        if (cnt_q == len_q) begin
          state_d = MC_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      MC_WR: begin
        if (cnt_q == (len_q - 3'd1)) begin
          state_d = MC_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = MC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MC_IDLE;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      port_q      <= PORT_IF;
      base_q      <= '0;
      last_a_q    <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      if (state_q == MC_IDLE) begin
        // Upper lanes of short loads must read back as zero.
        rbuf_q <= '0;
        if (mem_req_i) begin
          port_q  <= PORT_MEM;
          base_q  <= mem_addr_i[RAM_ADDR_W-1:0];
          len_q   <= size_to_len(mem_size_i);
          wdata_q <= mem_wdata_i;
        end else if (if_req_i) begin
          port_q  <= PORT_IF;
          base_q  <= if_addr_i[RAM_ADDR_W-1:0];
          len_q   <= 3'd4;
        end
      end

      if (state_q == MC_RD) begin
        rbuf_q <= rbuf_next;
        // Publish on the final capture so data is valid throughout DONE.
        if (cnt_q == len_q) begin
          if (port_q == PORT_IF) begin
            if_data_q <= rbuf_next;
          end else begin
            mem_rdata_q <= rbuf_next;
          end
        end
      end

      if (addr_phase) begin
        last_a_q <= cur_a;
      end
    end
  end

  assign ram_a_o     = addr_phase ? cur_a : last_a_q;
  assign ram_wr_o    = (state_q == MC_WR);
  assign ram_dout_o  = (state_q == MC_WR) ? wr_byte : 8'h00;
  assign if_done_o   = (state_q == MC_DONE) && (port_q == PORT_IF);
  assign mem_done_o  = (state_q == MC_DONE) && (port_q == PORT_MEM);
  assign if_data_o   = if_data_q;
  assign mem_rdata_o = mem_rdata_q;

endmodule
